// File: rtl/shift_ctrl_pkg.sv
// Shared types for the arbitrated serializer: FSM state encoding and reset
// value of the round-robin pointer.
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Pointer starts at requester 1, so requester 0 wins the first tie.
  localparam logic LAST_GRANT_RST = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational. The caller owns the
// last_grant pointer; on a tie the requester that was not served last wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/shift_arb_ctrl.sv
// Arbitrated serializer: grants one of two valid/ready requesters, loads the
// word into the shift register and sends it MSB-first, DIV cycles per bit.
//
// Handshake: a requester raises valid and holds valid and data steady until
// the cycle where its ready is also high; that cycle is the transfer. Ready is
// combinational, only ever high in IDLE, and never high for both requesters.
module shift_arb_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done,
  output logic             grant_id,
  output state_t           dbg_state
);

  localparam int BCW = $clog2(WIDTH);
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] shreg;
  logic [BCW-1:0]   bit_cnt;
  logic [DCW-1:0]   div_cnt;
  logic             last_grant;
  logic             gid;
  logic [1:0]       grant;
  logic             acc0;
  logic             acc1;
  logic             tick;
  logic             last_bit;

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // tick marks the final cycle of a bit's hold time.
  assign tick     = (state == SHIFT) && (div_cnt == DIV_LAST);
  assign last_bit = tick && (bit_cnt == BIT_LAST);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (acc0 || acc1) state_nx = SHIFT;
      SHIFT:   if (last_bit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state == IDLE) && !clear && grant[0];
    req1_ready = (state == IDLE) && !clear && grant[1];
    acc0       = req0_ready && req0_valid;
    acc1       = req1_ready && req1_valid;
    sout       = (state == SHIFT) ? shreg[WIDTH-1] : 1'b0;
    sout_valid = (state == SHIFT);
    busy       = (state != IDLE);
    done       = (state == DONE);
    grant_id   = gid;
    dbg_state  = state;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      last_grant <= LAST_GRANT_RST;
      gid        <= 1'b0;
    end else if (acc0 || acc1) begin
      shreg      <= acc1 ? req1_data : req0_data;
      gid        <= acc1;
      last_grant <= acc1;
      bit_cnt    <= '0;
      div_cnt    <= '0;
    end else if (state == SHIFT) begin
      if (tick) begin
        div_cnt <= '0;
        shreg   <= {shreg[WIDTH-2:0], 1'b0};
        // Park the bit counter at zero after the last bit instead of running on.
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shift_arb_ctrl.sv
// Bench for shift_arb_ctrl: a DIV=1 instance driven from a vector table and a
// DIV=3 instance driven by hand-written sequences, bits checked via queues.
module tb_shift_arb_ctrl;
  import shift_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  // DIV=1 instance signals
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [3:0] d0 = '0, d1 = '0;
  logic       r0, r1, so1, sv1, busy1, done1, gid1;
  state_t     st1;

  // DIV=3 instance signals
  logic       v0_3 = 1'b0, v1_3 = 1'b0;
  logic [3:0] d0_3 = '0, d1_3 = '0;
  logic       r0_3, r1_3, so3, sv3, busy3, done3, gid3;
  state_t     st3;

  shift_arb_ctrl #(.WIDTH(4), .DIV(1)) u_dut1 (
    .clock(clk), .clear(clear),
    .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
    .sout(so1), .sout_valid(sv1), .busy(busy1), .done(done1),
    .grant_id(gid1), .dbg_state(st1)
  );

  shift_arb_ctrl #(.WIDTH(4), .DIV(3)) u_dut3 (
    .clock(clk), .clear(clear),
    .req0_valid(v0_3), .req0_data(d0_3), .req0_ready(r0_3),
    .req1_valid(v1_3), .req1_data(d1_3), .req1_ready(r1_3),
    .sout(so3), .sout_valid(sv3), .busy(busy3), .done(done3),
    .grant_id(gid3), .dbg_state(st3)
  );

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q1[$];
  logic [0:0] exp_q3[$];
  int total = 0;
  int bad = 0;
  int done_cnt1 = 0;
  int done_cnt3 = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Push the expected serial bits of w: top nbits, each repeated div times.
  task automatic push_bits(input int which, input logic [3:0] w, input int div, input int nbits);
    for (int i = 3; i > 3 - nbits; i--) begin
      for (int k = 0; k < div; k++) begin
        if (which == 1) exp_q1.push_back(w[i]);
        else exp_q3.push_back(w[i]);
      end
    end
  endtask

  always @(negedge clk) begin
    logic [0:0] e;
    if (!clear) begin
      if (sv1) begin
        if (exp_q1.size() == 0) begin
          total++; bad++;
          $display("FAIL bit1_extra: sout_valid=1 sout=%0d with nothing expected", so1);
        end else begin
          e = exp_q1.pop_front();
          chk("sout1", int'(so1), int'(e));
        end
      end else begin
        chk("sout1_idle", int'(so1), 0);
      end
      if (sv3) begin
        if (exp_q3.size() == 0) begin
          total++; bad++;
          $display("FAIL bit3_extra: sout_valid=1 sout=%0d with nothing expected", so3);
        end else begin
          e = exp_q3.pop_front();
          chk("sout3", int'(so3), int'(e));
        end
      end else begin
        chk("sout3_idle", int'(so3), 0);
      end
      if (done1) done_cnt1++;
      if (done3) done_cnt3++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    clear = 1'b1;
    v0 = 1'b1; v1 = 1'b1; d0 = 4'hF; d1 = 4'hF;
    @(negedge clk);
    chk("rst_ready0", int'(r0), 0);
    chk("rst_ready1", int'(r1), 0);
    chk("rst_sout", int'(so1), 0);
    chk("rst_sout_valid", int'(sv1), 0);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_done", int'(done1), 0);
    chk("rst_grant_id", int'(gid1), 0);
    @(posedge clk); #1;
    clear = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    chk("rst_state_idle", int'(st1), int'(IDLE));
  endtask

  task automatic wait_done(input int which, input string name, input int exp_lat);
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!((which == 1) ? done1 : done3) && cyc < 60);
    chk(name, cyc, exp_lat);
  endtask

  typedef struct {
    logic       rst;
    logic       v0;
    logic [3:0] d0;
    logic       v1;
    logic [3:0] d1;
    logic       g;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl[NV];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc_before;
    //               rst   v0    d0     v1    d1     grant
    tbl[0] = '{1'b1, 1'b1, 4'hB, 1'b0, 4'h0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 4'hA, 1'b1, 4'h5, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 4'hA, 1'b1, 4'h5, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 4'h3, 1'b1, 4'hC, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 4'h3, 1'b1, 4'hC, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 4'h3, 1'b1, 4'hC, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 4'h3, 1'b1, 4'hC, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 4'h0, 1'b1, 4'h9, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 4'h6, 1'b0, 4'h0, 1'b0};
    tbl[9] = '{1'b0, 1'b1, 4'h0, 1'b1, 4'hF, 1'b1};

    // DIV=1 table: each frame's ready is expected the first IDLE cycle after
    // the previous done, and done WIDTH*DIV+1 cycles after acceptance.
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].rst) do_reset();
      @(posedge clk); #1;
      v0 = tbl[i].v0; d0 = tbl[i].d0;
      v1 = tbl[i].v1; d1 = tbl[i].d1;
      @(negedge clk);
      chk("grant_ready", int'({r1, r0}), tbl[i].g ? 2 : 1);
      push_bits(1, tbl[i].g ? tbl[i].d1 : tbl[i].d0, 1, 4);
      wait_done(1, "done_latency1", 5);
      chk("grant_id1", int'(gid1), int'(tbl[i].g));
      chk("queue1_empty", exp_q1.size(), 0);
    end
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    chk("done_pulses1", done_cnt1, NV);
    chk("idle_after_table", int'(busy1), 0);

    // DIV=3: req1 sends 4'b1100, each bit held three cycles.
    @(posedge clk); #1;
    v1_3 = 1'b1; d1_3 = 4'b1100;
    @(negedge clk);
    chk("div3_ready", int'({r1_3, r0_3}), 2);
    push_bits(3, 4'b1100, 3, 4);
    @(posedge clk); #1;
    v1_3 = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      chk("div3_busy", int'(busy3), 1);
      chk("div3_done", int'(done3), (k == 13) ? 1 : 0);
    end
    @(negedge clk);
    chk("div3_busy_end", int'(busy3), 0);
    chk("div3_grant_id", int'(gid3), 1);
    chk("queue3_empty", exp_q3.size(), 0);

    // Mid-frame reset after two bits of req1's frame.
    @(posedge clk); #1;
    v1_3 = 1'b1; d1_3 = 4'b1100;
    @(negedge clk);
    chk("mid_ready", int'({r1_3, r0_3}), 2);
    push_bits(3, 4'b1100, 3, 2);
    @(posedge clk); #1;
    v1_3 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("mid_busy", int'(busy3), 1);
    end
    dc_before = done_cnt3;
    #1;
    clear = 1'b1;
    v0_3 = 1'b1; d0_3 = 4'h6;
    v1_3 = 1'b1; d1_3 = 4'h9;
    #1;
    chk("mid_sout", int'(so3), 0);
    chk("mid_sout_valid", int'(sv3), 0);
    chk("mid_busy_clr", int'(busy3), 0);
    chk("mid_done", int'(done3), 0);
    chk("mid_grant_id", int'(gid3), 0);
    chk("mid_queue_drained", exp_q3.size(), 0);
    @(negedge clk);
    chk("mid_ready_in_clr", int'({r1_3, r0_3}), 0);
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    chk("mid_no_done", done_cnt3, dc_before);
    chk("post_rst_ready", int'({r1_3, r0_3}), 1);
    push_bits(3, 4'h6, 3, 4);
    @(posedge clk); #1;
    v0_3 = 1'b0; v1_3 = 1'b0;
    wait_done(3, "post_rst_latency", 13);
    chk("post_rst_grant_id", int'(gid3), 0);
    chk("queue3_final", exp_q3.size(), 0);
    @(negedge clk);
    chk("done_pulses3", done_cnt3, dc_before + 1);
    chk("queue1_final", exp_q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
